// File: rtl/fft_pkg.sv
// Shared FFT definitions: default sample geometry and LOG2N-bit index reversal.
package fft_pkg;
  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_LOG2N = 3;
  localparam int MAX_LOG2N     = 10;

  // Reverse all MAX_LOG2N bits, then shift so only the low log2n bits remain reversed.
  function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] idx,
                                                  input int log2n);
    logic [MAX_LOG2N-1:0] r;
    for (int i = 0; i < MAX_LOG2N; i++) begin
      r[i] = idx[MAX_LOG2N-1-i];
    end
    return r >> (MAX_LOG2N - log2n);
  endfunction
endpackage

// File: rtl/reorder_bank_ram.sv
// Two-bank sample store addressed {bank, index}; synchronous write, combinational read.
module reorder_bank_ram
  import fft_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int AW    = DEFAULT_LOG2N + 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/bit_reverse_reorder.sv
// Ping-pong reorder of bit-reversed FFT frames into natural order; out_valid rises the cycle
// after a frame's last input. Input stalls only while both banks hold unread frames.
module bit_reverse_reorder
  import fft_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int LOG2N = DEFAULT_LOG2N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);
  localparam logic [LOG2N-1:0] LAST_IDX = '1;

  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
  logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
  logic [LOG2N-1:0] wr_idx;
  logic             in_fire, out_fire, wr_last, rd_last;

  assign in_ready  = ~full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign out_last  = out_valid && (rd_cnt_q == LAST_IDX);

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign wr_last  = in_fire && (wr_cnt_q == LAST_IDX);
  assign rd_last  = out_fire && (rd_cnt_q == LAST_IDX);

  assign wr_idx = LOG2N'(bitrev(MAX_LOG2N'(wr_cnt_q), LOG2N));

  // Write and read can never target the same bank in one cycle (one needs it empty,
  // the other full), so setting and clearing flags never collide.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    if (in_fire) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
    end
    if (out_fire) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
    end
    if (wr_last) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end
    if (rd_last) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  reorder_bank_ram #(
    .WIDTH (WIDTH),
    .AW    (LOG2N + 1)
  ) u_ram (
    .clk     (clk),
    .wr_en   (in_fire),
    .wr_addr ({wr_bank_q, wr_idx}),
    .wr_data (in_data),
    .rd_addr ({rd_bank_q, rd_cnt_q}),
    .rd_data (out_data)
  );
endmodule

// File: tb/tb_bit_reverse_reorder.sv
// Directed bench for bit_reverse_reorder at N=8, plus N=2 and N=16 builds.
module tb_bit_reverse_reorder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;

  logic [31:0] in_data2 = '0;
  logic        in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b0, out_last2;
  logic [31:0] out_data2;
  logic [31:0] in_data16 = '0;
  logic        in_valid16 = 1'b0, in_ready16, out_valid16, out_ready16 = 1'b0, out_last16;
  logic [31:0] out_data16;

  int n_vec = 0;
  int n_err = 0;

  int brtab8[8]   = '{0, 4, 2, 6, 1, 5, 3, 7};
  int brtab2[2]   = '{0, 1};
  int brtab16[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  always #5 clk = ~clk;

  bit_reverse_reorder dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  bit_reverse_reorder #(.WIDTH(32), .LOG2N(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2), .out_last(out_last2)
  );

  bit_reverse_reorder #(.WIDTH(32), .LOG2N(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data16), .in_valid(in_valid16), .in_ready(in_ready16),
    .out_data(out_data16), .out_valid(out_valid16), .out_ready(out_ready16), .out_last(out_last16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #2;
    chk("rst_in_rdy", 32'(in_ready), 32'd1);
    chk("rst_out_vld", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_rdy", 32'(in_ready), 32'd1);
    chk("post_rst_out_vld", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Feed one bit-reversed frame of base+bitrev(k); out_ready stays low.
  task automatic feed_frame(input int base);
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_data  = base + brtab8[k];
      @(negedge clk);
      chk("feed_in_rdy", 32'(in_ready), 32'd1);
      chk("feed_out_vld", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain_frame(input int base);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("drain_vld", 32'(out_valid), 32'd1);
      chk("drain_dat", out_data, base + i);
      chk("drain_last", 32'(out_last), (i == 7) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic stream(input int nfr, input bit rnd);
    int sent, recv, gaps, rdy_lo, cyc;
    logic [31:0] pdat;
    bit pstall;
    sent = 0; recv = 0; gaps = 0; rdy_lo = 0; cyc = 0; pstall = 0; pdat = '0;
    while (recv < nfr * 8 && cyc < 2000) begin
      in_valid  = (sent < nfr * 8);
      in_data   = (sent / 8) * 8 + brtab8[sent % 8];
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (pstall) begin
        chk("stall_vld", 32'(out_valid), 32'd1);
        chk("stall_dat", out_data, pdat);
      end
      if (in_valid && !in_ready) rdy_lo++;
      if (recv > 0 && !out_valid) gaps++;
      if (out_valid && out_ready) begin
        chk("strm_dat", out_data, recv);
        chk("strm_last", 32'(out_last), (recv % 8 == 7) ? 32'd1 : 32'd0);
        recv++;
      end
      if (in_valid && in_ready) sent++;
      pstall = out_valid && !out_ready;
      pdat   = out_data;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("strm_count", recv, nfr * 8);
    if (!rnd) begin
      chk("strm_gaps", gaps, 0);
      chk("strm_in_rdy_low", rdy_lo, 0);
    end
  endtask

  initial begin
    // Single frame: latency, ordering and out_last.
    do_reset();
    feed_frame(0);
    chk("lat_out_vld", 32'(out_valid), 32'd1);
    drain_frame(0);
    @(negedge clk);
    chk("idle_out_vld", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back streaming.
    do_reset();
    stream(4, 1'b0);

    // Backpressure: two frames fill both banks, a third-frame sample is held.
    do_reset();
    for (int j = 0; j < 16; j++) begin
      in_valid = 1'b1;
      in_data  = (j / 8) * 8 + brtab8[j % 8];
      @(negedge clk);
      chk("bp_in_rdy", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
    end
    in_data = 32'hABCD;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_hold_rdy", 32'(in_ready), 32'd0);
      chk("bp_hold_vld", 32'(out_valid), 32'd1);
      chk("bp_hold_dat", out_data, 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("bp_drain_dat", out_data, i);
      chk("bp_drain_rdy", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    chk("bp_rdy_after", 32'(in_ready), 32'd1);
    chk("bp_second_dat", out_data, 32'd8);
    @(posedge clk);
    #1;
    in_valid = 1'b0;

    // Random downstream stalls.
    do_reset();
    stream(5, 1'b1);

    // Reset in the middle of a frame discards it.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = 100 + brtab8[k];
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    chk("mid_rst_out_vld", 32'(out_valid), 32'd0);
    chk("mid_rst_in_rdy", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    feed_frame(200);
    drain_frame(200);
    @(negedge clk);
    chk("mid_rst_no_extra", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;

    // N=2 build.
    for (int k = 0; k < 2; k++) begin
      in_valid2 = 1'b1;
      in_data2  = brtab2[k];
      @(posedge clk);
      #1;
    end
    in_valid2 = 1'b0;
    chk("n2_lat_vld", 32'(out_valid2), 32'd1);
    out_ready2 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("n2_dat", out_data2, i);
      chk("n2_last", 32'(out_last2), (i == 1) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready2 = 1'b0;

    // N=16 build.
    for (int k = 0; k < 16; k++) begin
      in_valid16 = 1'b1;
      in_data16  = brtab16[k];
      @(negedge clk);
      chk("n16_pre_vld", 32'(out_valid16), 32'd0);
      @(posedge clk);
      #1;
    end
    in_valid16 = 1'b0;
    chk("n16_lat_vld", 32'(out_valid16), 32'd1);
    out_ready16 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("n16_dat", out_data16, i);
      chk("n16_last", 32'(out_last16), (i == 15) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready16 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
